// File: rtl/kyber_pkg.sv
// Shared constants and FSM encoding for the Kyber byte encode/decode stream blocks.
package kyber_pkg;

    localparam int N_COEF = 256;
    localparam int D_MAX  = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A coefficient width is usable only in the range 1..dmax.
    function automatic logic d_sel_legal(input logic [3:0] d, input int unsigned dmax);
        return (d != 4'd0) && (32'(d) <= dmax);
    endfunction

endpackage

// File: rtl/byte_encode_stream_if.sv
// Coefficient-in / byte-out stream bundle. The master side feeds coefficients and
// consumes bytes; the slave side is the encoder.
interface byte_encode_stream_if #(
    parameter int D_MAX = kyber_pkg::D_MAX
) ();

    logic             coef_valid;
    logic [D_MAX-1:0] coef_data;
    logic             coef_ready;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             byte_last;
    logic             byte_ready;

    modport master (
        output coef_valid, coef_data, byte_ready,
        input  coef_ready, byte_valid, byte_data, byte_last
    );

    modport slave (
        input  coef_valid, coef_data, byte_ready,
        output coef_ready, byte_valid, byte_data, byte_last
    );

endinterface

// File: rtl/byte_encode_stream.sv
// Packs N_COEF coefficients of d bits each into an LSB-first byte stream.
// A (D_MAX+8)-bit accumulator collects coefficient bits; bytes leave from the bottom.
module byte_encode_stream #(
    parameter int N_COEF = kyber_pkg::N_COEF,
    parameter int D_MAX  = kyber_pkg::D_MAX
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [3:0]           d_sel,
    byte_encode_stream_if.slave  bus,
    output logic                 busy,
    output logic                 done
);

    import kyber_pkg::*;

    localparam int AW = D_MAX + 8;
    // Wide enough to hold both the fill ceiling D_MAX+7 and the constant 16.
    localparam int FW = $clog2(D_MAX + 17);
    localparam int CW = $clog2(N_COEF + 1);

    localparam logic [FW-1:0] FILL_BYTE = FW'(8);
    localparam logic [FW-1:0] FILL_TWO  = FW'(16);
    localparam logic [CW-1:0] CNT_END   = CW'(N_COEF);

    state_t        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    d_q, d_d;

    logic             byte_hs;
    logic             coef_acc;
    logic [D_MAX-1:0] coef_bits;
    logic [AW-1:0]    acc_base;
    logic [FW-1:0]    fill_base;

    // Stream handshakes and status outputs, all derived from registered state.
    always_comb begin
        bus.byte_valid = (state_q == RUN) && (fill_q >= FILL_BYTE);
        bus.byte_data  = acc_q[7:0];
        bus.byte_last  = (state_q == RUN) && (cnt_q == CNT_END) && (fill_q == FILL_BYTE);
        byte_hs        = bus.byte_valid && bus.byte_ready;
        // A coefficient fits only if the accumulator has room after any byte leaving this cycle.
        bus.coef_ready = (state_q == RUN) && (cnt_q < CNT_END) &&
                         ((fill_q < FILL_BYTE) || ((fill_q < FILL_TWO) && byte_hs));
        coef_acc       = bus.coef_valid && bus.coef_ready;
        busy           = (state_q == RUN);
        done           = (state_q == DONE);
    end

    // Next-state logic: drop the outgoing byte first, then append the new coefficient above the remaining bits.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;
        d_d       = d_q;
        coef_bits = bus.coef_data & ~({D_MAX{1'b1}} << d_q);
        acc_base  = byte_hs ? (acc_q >> 8) : acc_q;
        fill_base = byte_hs ? (fill_q - FILL_BYTE) : fill_q;

        unique case (state_q)
            IDLE: begin
                if (start && d_sel_legal(d_sel, D_MAX)) begin
                    state_d = RUN;
                    d_d     = d_sel;
                    acc_d   = '0;
                    fill_d  = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                acc_d  = acc_base;
                fill_d = fill_base;
                if (coef_acc) begin
                    acc_d  = acc_base | ({{8{1'b0}}, coef_bits} << fill_base);
                    fill_d = fill_base + {{(FW-4){1'b0}}, d_q};
                    cnt_d  = cnt_q + CW'(1);
                end
                if (byte_hs && bus.byte_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, accumulator and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            d_q     <= 4'd1;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
        end
    end

endmodule

// File: tb/tb_byte_encode_stream.sv
// Directed bench for byte_encode_stream: hand-computed byte constants plus a
// bit-level packing model, backpressure, illegal start and mid-run reset.
module tb_byte_encode_stream;

    localparam int N = 256;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] d_sel;
    logic       busy;
    logic       done;

    byte_encode_stream_if #(.D_MAX(12)) bus ();

    byte_encode_stream #(.N_COEF(N), .D_MAX(12)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .d_sel (d_sel),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    int unsigned coefs [N];
    logic [7:0]  expb  [384];
    logic [7:0]  got   [384];
    bit          ab;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit j of coefficient i lands at stream bit i*d+j.
    task automatic build_expected(input int d);
        for (int k = 0; k < 384; k++) expb[k] = 8'h00;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < d; j++) begin
                int pos = i * d + j;
                expb[pos / 8][pos % 8] = coefs[i][j];
            end
        end
    endtask

    // Runs one encode from a negedge. bp_at: byte index where 5 cycles of backpressure
    // start (-1 none). rst_at: byte count at which to abandon the run (-1 none).
    task automatic run_encode(input int d, input int bp_at, input int rst_at, output bit aborted);
        int   total      = N * d / 8;
        int   ci         = 0;
        int   bi         = 0;
        int   cyc        = 0;
        int   stall      = 0;
        int   bp_left    = 0;
        int   done_seen  = 0;
        int   first_acc  = -1;
        int   first_byte = -1;
        bit   bp_used    = 0;
        bit   hold       = 0;
        logic [7:0] held = 8'h00;

        build_expected(d);
        aborted = 0;
        start   = 1'b1;
        d_sel   = 4'(d);
        @(negedge clk);
        start = 1'b0;
        d_sel = 4'd0;
        check("busy_run", busy, 1);

        while (bi < total && cyc < 3000 && !aborted) begin
            bus.coef_valid = (ci < N);
            bus.coef_data  = (ci < N) ? coefs[ci][11:0] : 12'h000;
            if (bp_at >= 0 && !bp_used && bi == bp_at) begin
                bp_left = 5;
                bp_used = 1;
            end
            bus.byte_ready = (bp_left == 0);
            start = (cyc == 20);
            d_sel = 4'd3;
            #1;
            if (hold) begin
                check("hold_valid", bus.byte_valid, 1);
                check("hold_data", bus.byte_data, held);
            end
            hold = 0;
            if (bus.byte_valid && !bus.byte_ready) begin
                check("bp_coef_ready", bus.coef_ready, 0);
                held = bus.byte_data;
                hold = 1;
            end
            if (done) done_seen++;
            if (bus.byte_valid && first_byte < 0) first_byte = cyc;
            if (bus.coef_valid && bus.coef_ready) begin
                if (first_acc < 0) first_acc = cyc;
                ci++;
            end else if (bus.coef_valid && bp_at < 0 && d <= 8) begin
                stall++;
            end
            if (bus.byte_valid && bus.byte_ready) begin
                check($sformatf("byte%0d", bi), bus.byte_data, expb[bi]);
                check($sformatf("last%0d", bi), bus.byte_last, (bi == total - 1));
                got[bi] = bus.byte_data;
                bi++;
            end
            if (bp_left > 0) bp_left--;
            if (rst_at >= 0 && bi == rst_at) aborted = 1;
            @(negedge clk);
            cyc++;
        end
        start          = 1'b0;
        bus.coef_valid = 1'b0;
        bus.byte_ready = 1'b1;

        if (cyc >= 3000) check("timeout_bytes", bi, total);
        if (!aborted) begin
            check("done_pulse", done, 1);
            check("busy_after", busy, 0);
            check("done_during", done_seen, 0);
            check("byte_count", bi, total);
            if (d >= 8) check("latency", first_byte - first_acc, 1);
            if (bp_at < 0 && d <= 8) check("stalls", stall, 0);
            @(negedge clk);
            check("done_once", done, 0);
        end
    endtask

    task automatic outputs_zero(input string tag);
        check({tag, "_coef_ready"}, bus.coef_ready, 0);
        check({tag, "_byte_valid"}, bus.byte_valid, 0);
        check({tag, "_byte_data"}, bus.byte_data, 0);
        check({tag, "_byte_last"}, bus.byte_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic illegal_start(input logic [3:0] d);
        start = 1'b1;
        d_sel = d;
        @(negedge clk);
        start = 1'b0;
        check($sformatf("ill%0d_busy", d), busy, 0);
        check($sformatf("ill%0d_ready", d), bus.coef_ready, 0);
        repeat (3) @(negedge clk);
        check($sformatf("ill%0d_busy_later", d), busy, 0);
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        d_sel          = 4'd0;
        bus.coef_valid = 1'b0;
        bus.coef_data  = 12'h000;
        bus.byte_ready = 1'b1;
        repeat (2) @(negedge clk);
        outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // d=1, alternating 1,0 -> every byte 0x55
        for (int i = 0; i < N; i++) coefs[i] = (i % 2 == 0) ? 1 : 0;
        run_encode(1, -1, -1, ab);
        check("d1_first", got[0], 8'h55);
        check("d1_last", got[31], 8'h55);

        // d=12, 0x123, 0x456, zeros -> 23 61 45 ...
        for (int i = 0; i < N; i++) coefs[i] = 0;
        coefs[0] = 32'h123;
        coefs[1] = 32'h456;
        run_encode(12, -1, -1, ab);
        check("d12_b0", got[0], 8'h23);
        check("d12_b1", got[1], 8'h61);
        check("d12_b2", got[2], 8'h45);
        check("d12_b3", got[3], 8'h00);

        // d=4, i mod 16 with junk upper bits that must be discarded
        for (int i = 0; i < N; i++) coefs[i] = 32'(i % 16) | 32'hAB0;
        run_encode(4, -1, -1, ab);
        check("d4_b0", got[0], 8'h10);
        check("d4_b1", got[1], 8'h32);
        check("d4_b7", got[7], 8'hFE);
        check("d4_b8", got[8], 8'h10);
        check("d4_b127", got[127], 8'hFE);

        // illegal widths never leave IDLE
        illegal_start(4'd13);
        illegal_start(4'd0);

        // d=10, random coefficients, backpressure mid-stream
        for (int i = 0; i < N; i++) coefs[i] = $urandom_range(0, 4095);
        run_encode(10, 40, -1, ab);

        // d=11, reset mid-run then a clean run
        for (int i = 0; i < N; i++) coefs[i] = $urandom_range(0, 4095);
        run_encode(11, -1, 60, ab);
        check("d11_aborted", ab, 1);
        rst            = 1'b1;
        bus.coef_valid = 1'b1;
        bus.byte_ready = 1'b1;
        @(negedge clk);
        #1;
        outputs_zero("midrst");
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("postrst_valid%0d", k), bus.byte_valid, 0);
            check($sformatf("postrst_busy%0d", k), busy, 0);
        end
        bus.coef_valid = 1'b0;
        for (int i = 0; i < N; i++) coefs[i] = $urandom_range(0, 4095);
        run_encode(11, -1, -1, ab);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/byte_encode_stream.md
BYTE_ENCODE_STREAM -- requirements
Module: byte_encode_stream

Interface
REQ-001 SHALL have parameter N_COEF, default 256, coefficients per polynomial; SHALL be a multiple of 8.
REQ-002 SHALL have parameter D_MAX, default 12, maximum coefficient width in bits.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  begins one polynomial encode; sampled in IDLE only.
REQ-007 d_sel  input  4  coefficient width d, legal range 1..D_MAX; sampled with start.
REQ-008 coef_valid  input  1  coef_data is valid.
REQ-009 coef_data  input  D_MAX  coefficient; only bits [d-1:0] are used.
REQ-010 coef_ready  output  1  coefficient accepted when coef_valid && coef_ready.
REQ-011 byte_valid  output  1  byte_data is valid.
REQ-012 byte_data  output  8  packed output byte.
REQ-013 byte_last  output  1  marks the final byte of the polynomial; qualified by byte_valid.
REQ-014 byte_ready  input  1  byte consumed when byte_valid && byte_ready.
REQ-015 busy  output  1  high in RUN.
REQ-016 done  output  1  single-cycle pulse after the last byte handshake.

Function
REQ-017 SHALL pack the stream LSB-first: bit j of coefficient i goes to stream bit i*d+j, and byte k is stream bits 8k..8k+7 with bit 0 in byte_data[0].
REQ-018 SHALL emit exactly N_COEF*d/8 bytes per encode.
REQ-019 SHALL use three states: IDLE, RUN, DONE.
REQ-020 IDLE->RUN on start with 1<=d_sel<=D_MAX; SHALL latch d and clear the accumulator, fill count and coefficient count.
REQ-021 start with d_sel=0 or d_sel>D_MAX SHALL be ignored; the block stays in IDLE.
REQ-022 start in RUN or DONE SHALL be ignored.
REQ-023 RUN->DONE on the handshake of the byte carrying byte_last; DONE->IDLE unconditionally after one cycle, with done=1 during DONE.
REQ-024 Accumulator width SHALL be D_MAX+8 bits, with fill count 0..D_MAX+7.
REQ-025 byte_valid SHALL equal (state==RUN && fill>=8), and byte_data SHALL be accumulator bits [7:0].
REQ-026 coef_ready SHALL be high when state==RUN, coef count<N_COEF, and either fill<8, or fill<16 with a byte handshake in the same cycle.
REQ-027 A simultaneous byte handshake and coefficient accept in one cycle SHALL shift the accumulator right by 8, append the coefficient at the new fill position, and set fill = fill-8+d.
REQ-028 byte_last SHALL be high when coef count==N_COEF and fill==8.
REQ-029 byte_data, byte_valid and byte_last SHALL hold stable while byte_valid && !byte_ready.
REQ-030 Coefficient values SHALL NOT be reduced mod q; the upper bits of coef_data are discarded.
REQ-031 Throughput SHALL be one coefficient per cycle for d<=8 under no backpressure; for d>8 it is limited only by the byte output rate.
REQ-032 Latency SHALL be one cycle: a coefficient accepted in cycle t makes its first full byte visible in cycle t+1.

Reset
REQ-033 On rst: state=IDLE, accumulator=0, fill=0, counts=0, and d register=1.
REQ-034 On rst, all outputs SHALL be 0: coef_ready, byte_valid, byte_data, byte_last, busy, done.
REQ-035 rst mid-RUN SHALL abandon the encode with no further byte_valid; a new start is required.

Structure
REQ-036 A shared package kyber_pkg SHALL hold N_COEF, D_MAX and the state enum typedef, reused by future decode blocks.
REQ-037 No sub-module is needed; the block is a single module containing the FSM, accumulator and counters.

Verification
REQ-038 d=1, 256 coefficients alternating 1,0 -> 32 bytes, each 0x55; byte_last on byte 31; done pulses once.
REQ-039 d=12, coefficients 0x123, 0x456, then zeros -> bytes 0x23, 0x61, 0x45 first; 384 bytes total.
REQ-040 d=4, coefficients i mod 16 -> bytes 0x10, 0x32, ..., 0xFE repeating; 128 bytes total.
REQ-041 d=10, byte_ready low for 5 cycles mid-stream -> coef_ready drops, byte_data stays stable, no loss; the byte sequence matches the software model.
REQ-042 start with d_sel=13 -> busy stays 0; rst asserted mid-RUN at d=11 -> all outputs 0 next cycle, and a subsequent d=11 run is correct.
